// File: rtl/ctrl_pkg.sv
// Shared encodings for the control-line sequencer: ALU ops, write/read field codes, FSM states.
// Pure constants and types; no logic, no latency, no handshake.
package ctrl_pkg;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b11;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_RY   = 2'b01;
  localparam logic [1:0] WR_RX   = 2'b10;
  localparam logic [1:0] WR_BOTH = 2'b11;

  localparam logic [2:0] RD_RXA  = 3'b000;
  localparam logic [2:0] RD_RXB  = 3'b001;
  localparam logic [2:0] RD_RYA  = 3'b010;
  localparam logic [2:0] RD_RYB  = 3'b011;
  localparam logic [2:0] RD_BOTH = 3'b111;

  typedef enum logic [1:0] {EMPTY, HOLD, BEAT0, BEAT1} state_t;

  // Which slice of a word the decoder should produce
  localparam logic [1:0] BEAT_FULL   = 2'd0;
  localparam logic [1:0] BEAT_FIRST  = 2'd1;
  localparam logic [1:0] BEAT_SECOND = 2'd2;

endpackage

// File: rtl/ctrl_line_decode.sv
// Decodes one ins/cwr pair (or one half of a split write) into ALU op and per-register enables.
// Purely combinational, zero latency, no handshake.
module ctrl_line_decode
  import ctrl_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int IDX_W  = 5,
  parameter int RX_LSB = 7,
  parameter int RY_LSB = 0
) (
  input  logic [15:0]     ins,
  input  logic [33:0]     cwr,
  input  logic [1:0]      beat,
  output logic [1:0]      alu_op,
  output logic [NREG-1:0] load_reg,
  output logic [NREG-1:0] reg_to_bus,
  output logic [NREG-1:0] bus_sel,
  output logic            idx_err,
  output logic            split
);

  logic [IDX_W-1:0] rx, ry;
  logic [NREG-1:0]  rx_oh, ry_oh, wr_oh;
  logic             unused_bits;

  function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    if (int'(idx) < NREG) onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign rx      = ins[RX_LSB +: IDX_W];
  assign ry      = ins[RY_LSB +: IDX_W];
  assign rx_oh   = onehot(rx);
  assign ry_oh   = onehot(ry);
  assign idx_err = (int'(rx) >= NREG) || (int'(ry) >= NREG);
  assign split   = (cwr[13:12] == WR_BOTH) && (rx != ry);
  // Pass-through fields are handled by the top; fold them here so they are not dangling.
  assign unused_bits = ^{ins, cwr};

  always_comb begin
    alu_op = ALU_NAND;
    if (cwr[26] || ins[15:12] == 4'b0000) alu_op = ALU_ADD;
    else if (ins[15:12] == 4'b0001)       alu_op = ALU_SUB;

    case (cwr[13:12])
      WR_NONE: wr_oh = '0;
      WR_RY:   wr_oh = ry_oh;
      WR_RX:   wr_oh = rx_oh;
      default: wr_oh = rx_oh | ry_oh;
    endcase

    reg_to_bus = '0;
    bus_sel    = '0;
    case (cwr[11:9])
      RD_RXA:  reg_to_bus = rx_oh;
      RD_RXB:  begin reg_to_bus = rx_oh; bus_sel = rx_oh; end
      RD_RYA:  reg_to_bus = ry_oh;
      RD_RYB:  begin reg_to_bus = ry_oh; bus_sel = ry_oh; end
      // Rx on bus A wins when both reads name the same register
      RD_BOTH: begin reg_to_bus = rx_oh | ry_oh; bus_sel = ry_oh & ~rx_oh; end
      default: ;
    endcase

    load_reg = wr_oh;
    if (beat == BEAT_FIRST) begin
      load_reg = ry_oh;
    end else if (beat == BEAT_SECOND) begin
      load_reg   = rx_oh;
      reg_to_bus = '0;
      bus_sel    = '0;
    end
  end

endmodule

// File: rtl/ctrl_line_seq.sv
// Registered control-line decoder with valid/ready output and two-beat split of dual writes.
// One cycle accept-to-valid, full throughput; outputs hold while out_ready is low.
module ctrl_line_seq
  import ctrl_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int IDX_W    = 5,
  parameter int RX_LSB   = 7,
  parameter int RY_LSB   = 0,
  parameter int WR_PORTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     ins,
  input  logic [33:0]     cwr,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16:0]     pass_bits,
  output logic [1:0]      alu_op,
  output logic [NREG-1:0] load_reg,
  output logic [NREG-1:0] reg_to_bus,
  output logic [NREG-1:0] bus_sel,
  output logic            second_beat,
  output logic            idx_err
);

  state_t          state, state_nx;
  logic            accept, load_b1, split_go;
  logic [15:0]     ins_q, dec_ins;
  logic [33:0]     cwr_q, dec_cwr;
  logic [1:0]      dec_beat;
  logic [1:0]      d_alu, alu_q;
  logic [NREG-1:0] d_load, d_rtb, d_sel, load_q, rtb_q, sel_q;
  logic            d_err, d_split, err_q, sb_q;
  logic [16:0]     pass_q;

  // The second half of a split re-decodes the held word; everything else decodes the input
  assign dec_ins  = load_b1 ? ins_q : ins;
  assign dec_cwr  = load_b1 ? cwr_q : cwr;
  assign split_go = d_split && (WR_PORTS == 1);
  assign dec_beat = load_b1 ? BEAT_SECOND : (split_go ? BEAT_FIRST : BEAT_FULL);
  assign accept   = in_valid && in_ready;

  ctrl_line_decode #(
    .NREG(NREG), .IDX_W(IDX_W), .RX_LSB(RX_LSB), .RY_LSB(RY_LSB)
  ) u_decode (
    .ins(dec_ins), .cwr(dec_cwr), .beat(dec_beat),
    .alu_op(d_alu), .load_reg(d_load), .reg_to_bus(d_rtb), .bus_sel(d_sel),
    .idx_err(d_err), .split(d_split)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = split_go ? BEAT0 : HOLD;
      BEAT0:   if (out_ready) state_nx = BEAT1;
      default: if (out_ready) state_nx = accept ? (split_go ? BEAT0 : HOLD) : EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_b1   = 1'b0;
    if (!rst) begin
      out_valid = (state != EMPTY);
      load_b1   = (state == BEAT0) && out_ready;
      case (state)
        EMPTY:       in_ready = 1'b1;
        HOLD, BEAT1: in_ready = out_ready;
        default:     in_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q  <= '0;
      load_q <= '0;
      rtb_q  <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
      sb_q   <= 1'b0;
      pass_q <= '0;
      ins_q  <= '0;
      cwr_q  <= '0;
    end else if (accept || load_b1) begin
      alu_q  <= d_alu;
      load_q <= d_load;
      rtb_q  <= d_rtb;
      sel_q  <= d_sel;
      err_q  <= d_err;
      sb_q   <= load_b1;
      pass_q <= {dec_cwr[31:27], dec_cwr[25:14]};
      if (accept) begin
        ins_q <= ins;
        cwr_q <= cwr;
      end
    end else if (out_valid && out_ready) begin
      alu_q  <= '0;
      load_q <= '0;
      rtb_q  <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
      sb_q   <= 1'b0;
      pass_q <= '0;
    end
  end

  // Registers only clear on the edge, so mask them during the reset cycle itself
  assign alu_op      = rst ? '0 : alu_q;
  assign load_reg    = rst ? '0 : load_q;
  assign reg_to_bus  = rst ? '0 : rtb_q;
  assign bus_sel     = rst ? '0 : sel_q;
  assign idx_err     = rst ? 1'b0 : err_q;
  assign second_beat = rst ? 1'b0 : sb_q;
  assign pass_bits   = rst ? '0 : pass_q;

endmodule
